// File: rtl/mmio_arb_pkg.sv
// Shared types and constants for the MMIO arbiter slice.
//   AW_DEF/DW_DEF : default address/data widths
//   WIDTH_W       : width of the arWidth side-band field
//   RESP_*        : AXI-lite response encodings
//   rd_state_e, wr_state_e : one-hot FSM states; owner_e : read owner tag
package mmio_arb_pkg;

    localparam int unsigned AW_DEF  = 32;
    localparam int unsigned DW_DEF  = 32;
    localparam int unsigned WIDTH_W = 32;
    localparam int unsigned RESP_W  = 2;

    localparam logic [RESP_W-1:0] RESP_OKAY   = 2'b00;
    localparam logic [RESP_W-1:0] RESP_EXOKAY = 2'b01;
    localparam logic [RESP_W-1:0] RESP_SLVERR = 2'b10;
    localparam logic [RESP_W-1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        RD_IDLE = 3'b001,
        RD_AR   = 3'b010,
        RD_R    = 3'b100
    } rd_state_e;

    typedef enum logic [2:0] {
        WR_IDLE = 3'b001,
        WR_REQ  = 3'b010,
        WR_RESP = 3'b100
    } wr_state_e;

    typedef enum logic {
        M0 = 1'b0,
        M1 = 1'b1
    } owner_e;

endpackage

// File: rtl/mmio_arbiter_if.sv
// AXI-lite style MMIO bus (AR/R/AW/W/B channels).
//   master modport : drives request channels and rReady/bReady
//   slave modport  : drives ready signals and R/B response channels
interface mmio_arbiter_if #(
    parameter int unsigned AW = mmio_arb_pkg::AW_DEF,
    parameter int unsigned DW = mmio_arb_pkg::DW_DEF
);
    logic [AW-1:0]                    arAddr;
    logic [mmio_arb_pkg::WIDTH_W-1:0] arWidth;
    logic                             arValid;
    logic                             arReady;
    logic [DW-1:0]                    rData;
    logic                             rValid;
    logic                             rReady;
    logic [AW-1:0]                    awAddr;
    logic                             awValid;
    logic                             awReady;
    logic [DW-1:0]                    wData;
    logic [DW/8-1:0]                  wStrb;
    logic                             wValid;
    logic                             wReady;
    logic [mmio_arb_pkg::RESP_W-1:0]  bResp;
    logic                             bValid;
    logic                             bReady;

    modport master (
        output arAddr, arWidth, arValid, rReady,
        output awAddr, awValid, wData, wStrb, wValid, bReady,
        input  arReady, rData, rValid, awReady, wReady, bResp, bValid
    );

    modport slave (
        input  arAddr, arWidth, arValid, rReady,
        input  awAddr, awValid, wData, wStrb, wValid, bReady,
        output arReady, rData, rValid, awReady, wReady, bResp, bValid
    );
endinterface

// File: rtl/mmio_arbiter.sv
// Shares one MMIO slave port between IFU (m0, read-only) and LSU (m1, read+write).
// One outstanding read (round-robin, owner-tagged) and one outstanding write (LSU only);
// an LSU read and an LSU write are never in flight together.
//   clk, reset : clock, synchronous active-high reset
//   m0         : IFU bus (read channels only; write-side outputs tied off)
//   m1         : LSU bus
//   s          : bus to mmio_dpi
module mmio_arbiter
    import mmio_arb_pkg::*;
#(
    parameter int unsigned AW = AW_DEF,
    parameter int unsigned DW = DW_DEF
) (
    input  logic           clk,
    input  logic           reset,
    mmio_arbiter_if.slave  m0,
    mmio_arbiter_if.slave  m1,
    mmio_arbiter_if.master s
);
    localparam int unsigned SW = DW / 8;

    rd_state_e            rd_state, rd_next;
    wr_state_e            wr_state, wr_next;
    owner_e               rd_owner, last_grant, grant;
    logic                 rd_take, wr_take;
    logic                 m1_rd_busy, m1_rd_ok;
    logic                 ar_ack, wr_ack;
    logic                 aw_done, w_done, aw_fire, w_fire;
    logic                 r_ready;
    logic [AW-1:0]        ar_addr;
    logic [WIDTH_W-1:0]   ar_width;
    logic [AW-1:0]        aw_addr;
    logic [DW-1:0]        w_data;
    logic [SW-1:0]        w_strb;

    // IFU never writes; its write-side inputs are intentionally ignored
    logic unused_m0_wr;
    assign unused_m0_wr = ^{m0.awAddr, m0.awValid, m0.wData, m0.wStrb, m0.wValid, m0.bReady};

    // State registers and latched transactions
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_state   <= RD_IDLE;
            wr_state   <= WR_IDLE;
            rd_owner   <= M0;
            last_grant <= M1;
            ar_addr    <= '0;
            ar_width   <= '0;
            ar_ack     <= 1'b0;
            aw_addr    <= '0;
            w_data     <= '0;
            w_strb     <= '0;
            wr_ack     <= 1'b0;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
        end else begin
            rd_state <= rd_next;
            wr_state <= wr_next;
            ar_ack   <= rd_take;
            wr_ack   <= wr_take;
            if (rd_take) begin
                rd_owner   <= grant;
                last_grant <= grant;
                ar_addr    <= (grant == M1) ? m1.arAddr  : m0.arAddr;
                ar_width   <= (grant == M1) ? m1.arWidth : m0.arWidth;
            end
            if (wr_take) begin
                aw_addr <= m1.awAddr;
                w_data  <= m1.wData;
                w_strb  <= m1.wStrb;
            end
            // Per-channel done flags live only while in WR_REQ
            aw_done <= (wr_state == WR_REQ) && (wr_next == WR_REQ) && (aw_done || aw_fire);
            w_done  <= (wr_state == WR_REQ) && (wr_next == WR_REQ) && (w_done  || w_fire);
        end
    end

    // Next-state and output decode for both FSMs
    always_comb begin
        rd_next    = rd_state;
        wr_next    = wr_state;
        rd_take    = 1'b0;
        aw_fire    = 1'b0;
        w_fire     = 1'b0;
        r_ready    = 1'b0;

        m0.arReady = 1'b0;
        m0.rData   = '0;
        m0.rValid  = 1'b0;
        m0.awReady = 1'b0;
        m0.wReady  = 1'b0;
        m0.bResp   = '0;
        m0.bValid  = 1'b0;
        m1.arReady = 1'b0;
        m1.rData   = '0;
        m1.rValid  = 1'b0;
        m1.awReady = 1'b0;
        m1.wReady  = 1'b0;
        m1.bResp   = '0;
        m1.bValid  = 1'b0;
        s.arAddr   = ar_addr;
        s.arWidth  = ar_width;
        s.arValid  = 1'b0;
        s.rReady   = 1'b0;
        s.awAddr   = aw_addr;
        s.awValid  = 1'b0;
        s.wData    = w_data;
        s.wStrb    = w_strb;
        s.wValid   = 1'b0;
        s.bReady   = 1'b0;

        // LSU write wins over a same-cycle LSU read; an LSU read blocks new writes
        m1_rd_busy = (rd_state != RD_IDLE) && (rd_owner == M1);
        wr_take    = (wr_state == WR_IDLE) && m1.awValid && m1.wValid && !m1_rd_busy;
        m1_rd_ok   = m1.arValid && (wr_state == WR_IDLE) && !wr_take;
        grant      = (m1_rd_ok && (!m0.arValid || last_grant == M0)) ? M1 : M0;

        // Request accept pulses, one cycle after the request was latched
        m0.arReady = ar_ack && (rd_owner == M0);
        m1.arReady = ar_ack && (rd_owner == M1);
        m1.awReady = wr_ack;
        m1.wReady  = wr_ack;

        case (rd_state)
            RD_IDLE: begin
                if (m0.arValid || m1_rd_ok) begin
                    rd_take = 1'b1;
                    rd_next = RD_AR;
                end
            end
            RD_AR: begin
                s.arValid = 1'b1;
                if (s.arReady) rd_next = RD_R;
            end
            RD_R: begin
                r_ready  = (rd_owner == M1) ? m1.rReady : m0.rReady;
                s.rReady = r_ready;
                if (rd_owner == M1) begin
                    m1.rValid = s.rValid;
                    m1.rData  = s.rData;
                end else begin
                    m0.rValid = s.rValid;
                    m0.rData  = s.rData;
                end
                if (s.rValid && r_ready) rd_next = RD_IDLE;
            end
            default: rd_next = RD_IDLE;
        endcase

        case (wr_state)
            WR_IDLE: begin
                if (wr_take) wr_next = WR_REQ;
            end
            WR_REQ: begin
                s.awValid = !aw_done;
                s.wValid  = !w_done;
                aw_fire   = !aw_done && s.awReady;
                w_fire    = !w_done && s.wReady;
                if ((aw_done || aw_fire) && (w_done || w_fire)) wr_next = WR_RESP;
            end
            WR_RESP: begin
                s.bReady  = m1.bReady;
                m1.bValid = s.bValid;
                m1.bResp  = s.bResp;
                if (s.bValid && m1.bReady) wr_next = WR_IDLE;
            end
            default: wr_next = WR_IDLE;
        endcase
    end

endmodule
